// File: rtl/cordic_pkg.sv
//------------------------------------------------------------------------------
// cordic_pkg : constants, state encoding and saturation shared by CORDIC engines
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cordic_pkg;

  localparam int          CORDIC_DW    = 16;
  localparam int          CORDIC_NITER = 16;
  localparam logic [15:0] CORDIC_K     = 16'h4DBA;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ITER  = 2'd1,
    ST_SCALE = 2'd2
  } cordic_state_e;

  // Clamp a wide signed value into the signed CORDIC_DW output range.
  function automatic logic [CORDIC_DW-1:0] sat_dw(input logic signed [63:0] v);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (CORDIC_DW - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      sat_dw = {1'b0, {(CORDIC_DW-1){1'b1}}};
    end else if (v < lo) begin
      sat_dw = {1'b1, {(CORDIC_DW-1){1'b0}}};
    end else begin
      sat_dw = v[CORDIC_DW-1:0];
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/cordic_microrot_stage.sv
//------------------------------------------------------------------------------
// cordic_microrot_stage : one combinational shift-add CORDIC micro-rotation
// Revision              : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cordic_microrot_stage #(
  parameter int W  = 18,
  parameter int SW = 5
) (
  input  logic signed [W-1:0]  x,
  input  logic signed [W-1:0]  y,
  input  logic        [SW-1:0] shift,
  input  logic                 dir,
  output logic signed [W-1:0]  x_next,
  output logic signed [W-1:0]  y_next
);

  logic signed [W-1:0] x_sh;
  logic signed [W-1:0] y_sh;

  always_comb begin
    x_sh = x >>> shift;
    y_sh = y >>> shift;
    // dir=1 rotates counter-clockwise (d=+1), dir=0 clockwise (d=-1)
    if (dir) begin
      x_next = x - y_sh;
      y_next = y + x_sh;
    end else begin
      x_next = x + y_sh;
      y_next = y - x_sh;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cordic_rotation_replay.sv
//------------------------------------------------------------------------------
// cordic_rotation_replay : iterative rotation-mode CORDIC replaying a direction word
// Revision               : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cordic_rotation_replay
  import cordic_pkg::*;
#(
  parameter int N_ITER = CORDIC_NITER,
  parameter int DW     = CORDIC_DW,
  parameter int GW     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_cr,
  input  logic signed [DW-1:0] xin_cr,
  input  logic signed [DW-1:0] yin_cr,
  input  logic        [31:0]   cr_di_microt,
  output logic        [DW-1:0] cr_cos_theta,
  output logic        [DW-1:0] cr_sin_theta,
  output logic                 cr_calc_end,
  output logic                 busy
);

  localparam int IW = DW + GW;
  localparam int PW = IW + 16;
  localparam int CW = 5;
  localparam logic signed [PW-1:0] C_K = PW'(CORDIC_K);

  cordic_state_e        state_q, state_d;
  logic [CW-1:0]        i_q, i_d;
  logic signed [IW-1:0] x_q, x_d, y_q, y_d;
  logic [31:0]          di_q, di_d;
  logic [DW-1:0]        cos_q, cos_d, sin_q, sin_d;
  logic                 end_q, end_d, busy_q, busy_d;

  logic signed [IW-1:0] x_nx, y_nx;
  logic signed [PW-1:0] x_prod, y_prod;

  cordic_microrot_stage #(.W(IW), .SW(CW)) u_stage (
    .x      (x_q),
    .y      (y_q),
    .shift  (i_q),
    .dir    (di_q[i_q]),
    .x_next (x_nx),
    .y_next (y_nx)
  );

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    x_d     = x_q;
    y_d     = y_q;
    di_d    = di_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    end_d   = 1'b0;
    busy_d  = busy_q;
    x_prod  = PW'(x_q) * C_K;
    y_prod  = PW'(y_q) * C_K;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        // The strobe cycle still counts as busy, so a start there is dropped.
        if (start_cr && !end_q) begin
          x_d     = IW'(xin_cr);
          y_d     = IW'(yin_cr);
          di_d    = cr_di_microt;
          i_d     = '0;
          busy_d  = 1'b1;
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        x_d = x_nx;
        y_d = y_nx;
        i_d = i_q + CW'(1);
        if (i_q == CW'(N_ITER - 1)) begin
          state_d = ST_SCALE;
        end
      end
      ST_SCALE: begin
        cos_d   = sat_dw(64'(x_prod >>> 15));
        sin_d   = sat_dw(64'(y_prod >>> 15));
        end_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      di_q    <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      x_q     <= x_d;
      y_q     <= y_d;
      di_q    <= di_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
      end_q   <= end_d;
      busy_q  <= busy_d;
    end
  end

  assign cr_cos_theta = cos_q;
  assign cr_sin_theta = sin_q;
  assign cr_calc_end  = end_q;
  assign busy         = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_cordic_rotation_replay.sv
//------------------------------------------------------------------------------
// tb_cordic_rotation_replay : directed self-checking bench for cordic_rotation_replay
// Revision                  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cordic_rotation_replay;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_cr = 1'b0;
  logic [15:0] xin_cr = '0;
  logic [15:0] yin_cr = '0;
  logic [31:0] cr_di_microt = '0;
  logic [15:0] cr_cos_theta;
  logic [15:0] cr_sin_theta;
  logic        cr_calc_end;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cordic_rotation_replay dut (
    .clk          (clk),
    .rst          (rst),
    .start_cr     (start_cr),
    .xin_cr       (xin_cr),
    .yin_cr       (yin_cr),
    .cr_di_microt (cr_di_microt),
    .cr_cos_theta (cr_cos_theta),
    .cr_sin_theta (cr_sin_theta),
    .cr_calc_end  (cr_calc_end),
    .busy         (busy)
  );

  // Reference: unbounded-precision replay of 16 micro-rotations, K scaling, clamp.
  function automatic logic [15:0] model(input int xi, input int yi,
                                        input logic [31:0] di, input bit want_sin);
    longint x, y, xs, ys, p;
    logic [15:0] r;
    x = xi;
    y = yi;
    for (int i = 0; i < 16; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      if (di[i]) begin
        x = x - ys;
        y = y + xs;
      end else begin
        x = x + ys;
        y = y - xs;
      end
    end
    p = (want_sin ? y : x) * 64'sd19898;
    p = p >>> 15;
    if (p > 32767) p = 32767;
    if (p < -32768) p = -32768;
    r = p[15:0];
    return r;
  endfunction

  function automatic bit near(input logic [15:0] a, input logic [15:0] b, input int tol);
    int d;
    d = int'($signed(a)) - int'($signed(b));
    return (d <= tol) && (d >= -tol);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Launch one operation, scramble inputs after the latch, wait for the strobe.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic [31:0] di,
                        output int lat, output int busy_cnt);
    @(posedge clk); #1;
    xin_cr = x; yin_cr = y; cr_di_microt = di; start_cr = 1'b1;
    @(posedge clk); #1;
    start_cr = 1'b0; xin_cr = 16'h5A5A; yin_cr = 16'hA5A5; cr_di_microt = ~di;
    lat = 1;
    busy_cnt = 0;
    while (!cr_calc_end && lat < 40) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy) busy_cnt++;
  endtask

  initial begin
    int lat, bcnt, pulses, first, second;
    logic b18, b19, seen;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cos", 32'(cr_cos_theta), 32'h0);
    check("rst_sin", 32'(cr_sin_theta), 32'h0);
    check("rst_end", 32'(cr_calc_end), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // Zero vector: latency and busy duration
    run_op(16'h0000, 16'h0000, 32'hDEADBEEF, lat, bcnt);
    check("zero_latency", 32'(lat), 32'd18);
    check("zero_busy_cycles", 32'(bcnt), 32'd18);
    check("zero_cos", 32'(cr_cos_theta), 32'h0);
    check("zero_sin", 32'(cr_sin_theta), 32'h0);
    @(posedge clk); #1;
    check("strobe_one_cycle", 32'(cr_calc_end), 32'h0);
    check("idle_not_busy", 32'(busy), 32'h0);

    // All-positive directions: +1.7433 rad
    run_op(16'h7FFF, 16'h0000, 32'hFFFFFFFF, lat, bcnt);
    check("pos_cos_model", 32'(cr_cos_theta), 32'(model(32767, 0, 32'hFFFFFFFF, 1'b0)));
    check("pos_sin_model", 32'(cr_sin_theta), 32'(model(32767, 0, 32'hFFFFFFFF, 1'b1)));
    check("pos_cos_near_EA05", 32'(near(cr_cos_theta, 16'hEA05, 16)), 32'd1);
    check("pos_sin_near_7E18", 32'(near(cr_sin_theta, 16'h7E18, 16)), 32'd1);

    // All-negative directions: -1.7433 rad
    run_op(16'h7FFF, 16'h0000, 32'h00000000, lat, bcnt);
    check("neg_cos_model", 32'(cr_cos_theta), 32'(model(32767, 0, 32'h0, 1'b0)));
    check("neg_sin_model", 32'(cr_sin_theta), 32'(model(32767, 0, 32'h0, 1'b1)));
    check("neg_cos_near_EA05", 32'(near(cr_cos_theta, 16'hEA05, 16)), 32'd1);
    check("neg_sin_near_81E8", 32'(near(cr_sin_theta, 16'h81E8, 16)), 32'd1);

    // Upper direction bits must be ignored
    run_op(16'h7FFF, 16'h0000, 32'hFFFF0000, lat, bcnt);
    check("hibits_cos", 32'(cr_cos_theta), 32'(model(32767, 0, 32'h0, 1'b0)));
    check("hibits_sin", 32'(cr_sin_theta), 32'(model(32767, 0, 32'h0, 1'b1)));

    // Saturation: x' ~ -1.157 clamps, y' ~ +0.813 in range
    run_op(16'h7FFF, 16'h7FFF, 32'h0000FFFF, lat, bcnt);
    check("sat_cos_clamped", 32'(cr_cos_theta), 32'h8000);
    check("sat_sin_model", 32'(cr_sin_theta), 32'(model(32767, 32767, 32'h0000FFFF, 1'b1)));

    // Busy protocol: starts at cycles 0, 5, 18 (strobe cycle), 19
    @(posedge clk); #1;
    @(posedge clk); #1;
    xin_cr = 16'h7FFF; yin_cr = 16'h0000; cr_di_microt = 32'hFFFFFFFF;
    pulses = 0; first = -1; second = -1; b18 = 1'b0; b19 = 1'b1;
    for (int c = 0; c < 46; c++) begin
      start_cr = (c == 0) || (c == 5) || (c == 18) || (c == 19);
      if (cr_calc_end) begin
        pulses++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      if (c == 18) b18 = busy;
      if (c == 19) b19 = busy;
      @(posedge clk); #1;
    end
    start_cr = 1'b0;
    check("proto_pulses", 32'(pulses), 32'd2);
    check("proto_first", 32'(first), 32'd18);
    check("proto_second", 32'(second), 32'd37);
    check("proto_busy_c18", 32'(b18), 32'd1);
    check("proto_busy_c19", 32'(b19), 32'd0);
    check("proto_sin", 32'(cr_sin_theta), 32'(model(32767, 0, 32'hFFFFFFFF, 1'b1)));

    // Reset during iteration 7
    @(posedge clk); #1;
    xin_cr = 16'h4000; yin_cr = 16'h2000; cr_di_microt = 32'h0000A5A5; start_cr = 1'b1;
    @(posedge clk); #1;
    start_cr = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_cos", 32'(cr_cos_theta), 32'h0);
    check("midrst_sin", 32'(cr_sin_theta), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (cr_calc_end) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("midrst_no_strobe", 32'(seen), 32'h0);

    run_op(16'h4000, 16'h2000, 32'h0000A5A5, lat, bcnt);
    check("fresh_latency", 32'(lat), 32'd18);
    check("fresh_cos", 32'(cr_cos_theta), 32'(model(16384, 8192, 32'h0000A5A5, 1'b0)));
    check("fresh_sin", 32'(cr_sin_theta), 32'(model(16384, 8192, 32'h0000A5A5, 1'b1)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
